// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution reader.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } exec_state_t;

    typedef logic signed [63:0] result_t;

endpackage

// File: rtl/instr_exec_reader_if.sv
// Result stream of the instruction reader: payload plus valid/ready handshake.
interface instr_exec_reader_if #(
    parameter int ADDR_W = 5
);
    import instr_register_pkg::*;

    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] res_pointer;
    opcode_t           res_opc;
    result_t           res_value;

    modport master (
        output res_valid,
        output res_pointer,
        output res_opc,
        output res_value,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_pointer,
        input  res_opc,
        input  res_value,
        output res_ready
    );

endinterface

// File: rtl/instr_exec_alu.sv
// Combinational opcode executor: sign-extends both operands to 64 bits and
// applies the opcode. Division by zero and unknown opcodes yield 0.
module instr_exec_alu
    import instr_register_pkg::*;
(
    input  opcode_t  opc_i,
    input  operand_t op_a_i,
    input  operand_t op_b_i,
    output result_t  result_o
);

    result_t a_ext;
    result_t b_ext;

    assign a_ext = {{32{op_a_i[31]}}, op_a_i};
    assign b_ext = {{32{op_b_i[31]}}, op_b_i};

    // Opcode decode; the 64-bit signed operators give the full product and
    // truncate-toward-zero division with remainder taking the dividend's sign.
    always_comb begin
        result_o = '0;
        case (opc_i)
            ZERO:    result_o = '0;
            PASSA:   result_o = a_ext;
            PASSB:   result_o = b_ext;
            ADD:     result_o = a_ext + b_ext;
            SUB:     result_o = a_ext - b_ext;
            MULT:    result_o = a_ext * b_ext;
            DIV:     if (b_ext != '0) result_o = a_ext / b_ext;
            MOD:     if (b_ext != '0) result_o = a_ext % b_ext;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec_reader.sv
// Walks read_pointer over a programmed window of the instruction register,
// executes each entry and streams one result at a time over valid/ready.
module instr_exec_reader
    import instr_register_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_ptr,
    input  logic [CNT_W-1:0]    count,
    input  instruction_t        instruction_word,
    output logic [ADDR_W-1:0]   read_pointer,
    instr_exec_reader_if.master res,
    output logic                busy,
    output logic                done
);

    exec_state_t       state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  remaining_q;
    instruction_t      instr_q;
    logic              res_valid_q;
    logic [ADDR_W-1:0] res_pointer_q;
    opcode_t           res_opc_q;
    result_t           res_value_q;
    logic              busy_q;
    logic              done_q;
    result_t           alu_d;

    instr_exec_alu u_alu (
        .opc_i    (instr_q.opc),
        .op_a_i   (instr_q.op_a),
        .op_b_i   (instr_q.op_b),
        .result_o (alu_d)
    );

    // Window sequencer: fetch, execute, hold the result until accepted, repeat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            remaining_q   <= '0;
            instr_q       <= '0;
            res_valid_q   <= 1'b0;
            res_pointer_q <= '0;
            res_opc_q     <= ZERO;
            res_value_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (count != '0) begin
                            ptr_q       <= start_ptr;
                            remaining_q <= count;
                            state_q     <= FETCH;
                        end else begin
                            // Empty window: report completion without touching the register.
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                FETCH: begin
                    instr_q <= instruction_word;
                    state_q <= EXEC;
                end
                EXEC: begin
                    res_valid_q   <= 1'b1;
                    res_pointer_q <= ptr_q;
                    res_opc_q     <= instr_q.opc;
                    res_value_q   <= alu_d;
                    state_q       <= HOLD;
                end
                HOLD: begin
                    if (res.res_ready) begin
                        res_valid_q <= 1'b0;
                        ptr_q       <= ptr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign read_pointer    = ptr_q;
    assign res.res_valid   = res_valid_q;
    assign res.res_pointer = res_pointer_q;
    assign res.res_opc     = res_opc_q;
    assign res.res_value   = res_value_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
